// File: rtl/instr_mem_sync_if.sv
// Bus between the fetch/load requester and instr_mem_sync.
// master drives requests; slave (the memory) returns fetch results and status.
interface instr_mem_sync_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              stall;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] instr_addr;
  logic              fault;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_err;
  logic              clear_req;
  logic              busy;

  modport master (
    output fetch_req, fetch_addr, stall, load_en, load_addr, load_data, clear_req,
    input  instr, instr_valid, instr_addr, fault, load_err, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, stall, load_en, load_addr, load_data, clear_req,
    output instr, instr_valid, instr_addr, fault, load_err, busy
  );
endinterface

// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory: registered fetch port with stall hold, bootload
// write port with write-first bypass, and a sequencer that fills the array with NOP.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | fetches and loads serviced; clear_req starts a clear
// ST_CLEAR | writing NOP_INSTR to one word per cycle; fetches/loads dropped
module instr_mem_sync #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input logic             clk,
  input logic             reset,
  instr_mem_sync_if.slave bus
);

  localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state;
  logic [IDX_W-1:0]  clr_cnt;

  logic             idle;
  logic             fetch_in_range;
  logic             load_in_range;
  logic             do_fetch;
  logic             do_load;
  logic             load_hit;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] load_idx;

  assign idle           = (state == ST_IDLE);
  assign fetch_in_range = ({1'b0, bus.fetch_addr} < DEPTH_L);
  assign load_in_range  = ({1'b0, bus.load_addr} < DEPTH_L);
  assign fetch_idx      = bus.fetch_addr[IDX_W-1:0];
  assign load_idx       = bus.load_addr[IDX_W-1:0];
  assign do_fetch       = idle & ~bus.stall & bus.fetch_req;
  assign do_load        = idle & bus.load_en & load_in_range;
  assign load_hit       = do_load & (bus.load_addr == bus.fetch_addr);
  assign bus.busy       = (state == ST_CLEAR);

  // Array has no reset; a reset mid-clear leaves partially cleared contents.
  always_ff @(posedge clk) begin
    if (!idle) begin
      mem[clr_cnt] <= NOP_INSTR;
    end else if (do_load) begin
      mem[load_idx] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.instr       <= NOP_INSTR;
      bus.instr_valid <= 1'b0;
      bus.instr_addr  <= '0;
      bus.fault       <= 1'b0;
    end else if (!bus.stall) begin
      bus.instr_valid <= do_fetch;
      if (do_fetch) begin
        bus.instr_addr <= bus.fetch_addr;
        bus.fault      <= ~fetch_in_range;
        if (!fetch_in_range) begin
          bus.instr <= NOP_INSTR;
        end else if (load_hit) begin
          bus.instr <= bus.load_data;
        end else begin
          bus.instr <= mem[fetch_idx];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.load_err <= 1'b0;
    end else begin
      bus.load_err <= bus.load_en & (~load_in_range | ~idle);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      clr_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (bus.clear_req) begin
        state   <= ST_CLEAR;
        clr_cnt <= '0;
      end
    end else begin
      if (clr_cnt == LAST_IDX) begin
        state   <= ST_IDLE;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural memory model.
module tb_instr_mem_sync;
  localparam int          DATA_W = 16;
  localparam int          ADDR_W = 4;
  localparam int          DEPTH  = 8;
  localparam logic [15:0] NOP    = 16'hE000;

  logic clk = 1'b0;
  logic reset;

  instr_mem_sync_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  instr_mem_sync #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an array plus "clear words remaining".
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  int          clear_left = 0;
  logic [15:0] e_instr = NOP;
  bit          e_known = 1;
  logic        e_valid = 0;
  logic [3:0]  e_addr  = '0;
  logic        e_fault = 0;
  logic        e_err   = 0;
  bit          m_busy;
  int          m_fa;
  int          m_la;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_left = 0;
      e_instr = NOP; e_known = 1; e_valid = 0; e_addr = '0; e_fault = 0; e_err = 0;
    end else begin
      m_busy = clear_left > 0;
      m_fa = int'(bus.fetch_addr);
      m_la = int'(bus.load_addr);
      if (!bus.stall) begin
        e_valid = !m_busy && bus.fetch_req;
        if (e_valid) begin
          e_addr = bus.fetch_addr;
          if (m_fa >= DEPTH) begin
            e_fault = 1; e_instr = NOP; e_known = 1;
          end else begin
            e_fault = 0;
            if (bus.load_en && m_la == m_fa) begin
              e_instr = bus.load_data; e_known = 1;
            end else begin
              e_instr = m_mem[m_fa]; e_known = m_known[m_fa];
            end
          end
        end
      end
      e_err = bus.load_en && (m_la >= DEPTH || m_busy);
      if (m_busy) begin
        m_mem[DEPTH - clear_left] = NOP;
        m_known[DEPTH - clear_left] = 1;
        clear_left--;
      end else begin
        if (bus.load_en && m_la < DEPTH) begin
          m_mem[m_la] = bus.load_data;
          m_known[m_la] = 1;
        end
        if (bus.clear_req) clear_left = DEPTH;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("m_busy", bus.busy, 32'(clear_left > 0));
      check("m_valid", bus.instr_valid, e_valid);
      check("m_addr", bus.instr_addr, e_addr);
      check("m_fault", bus.fault, e_fault);
      check("m_load_err", bus.load_err, e_err);
      if (e_known) check("m_instr", bus.instr, e_instr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_req = 0; bus.fetch_addr = '0; bus.stall = 0;
    bus.load_en = 0; bus.load_addr = '0; bus.load_data = '0; bus.clear_req = 0;
  endtask

  logic [15:0] prog [7];
  int n;

  initial begin
    prog[0] = 16'h2C03; prog[1] = 16'h8180; prog[2] = 16'h2204; prog[3] = 16'h0083;
    prog[4] = 16'h6182; prog[5] = 16'hA102; prog[6] = 16'h4581;
    idle_inputs();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_instr", bus.instr, NOP);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_addr", bus.instr_addr, 0);
    check("rst_fault", bus.fault, 0);
    check("rst_load_err", bus.load_err, 0);
    check("rst_busy", bus.busy, 0);
    reset = 0;
    cmp_en = 1;

    for (int i = 0; i < 7; i++) begin
      bus.load_en = 1; bus.load_addr = 4'(i); bus.load_data = prog[i];
      step();
    end
    idle_inputs();

    for (int i = 0; i < 7; i++) begin
      bus.fetch_req = 1; bus.fetch_addr = 4'(i);
      step();
      check("prog_instr", bus.instr, prog[i]);
      check("prog_valid", bus.instr_valid, 1);
      check("prog_addr", bus.instr_addr, i);
      check("prog_fault", bus.fault, 0);
    end
    idle_inputs();
    step();
    check("nofetch_valid", bus.instr_valid, 0);
    check("nofetch_hold", bus.instr, 16'h4581);

    bus.fetch_req = 1; bus.fetch_addr = 4'd9;
    step();
    check("oor_instr", bus.instr, NOP);
    check("oor_fault", bus.fault, 1);
    check("oor_valid", bus.instr_valid, 1);
    idle_inputs();
    bus.load_en = 1; bus.load_addr = 4'd12; bus.load_data = 16'h1234;
    step();
    check("oor_load_err", bus.load_err, 1);
    idle_inputs();
    step();
    check("oor_load_err_end", bus.load_err, 0);

    bus.fetch_req = 1; bus.fetch_addr = 4'd3;
    step();
    check("pre_stall", bus.instr, 16'h0083);
    bus.stall = 1; bus.fetch_addr = 4'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr", bus.instr, 16'h0083);
      check("stall_valid", bus.instr_valid, 1);
      check("stall_addr", bus.instr_addr, 3);
    end
    bus.stall = 0;
    step();
    check("post_stall", bus.instr, 16'h6182);

    bus.load_en = 1; bus.load_addr = 4'd5; bus.load_data = 16'hBEEF;
    bus.fetch_req = 1; bus.fetch_addr = 4'd5;
    step();
    check("bypass", bus.instr, 16'hBEEF);
    bus.load_en = 0;
    step();
    check("after_bypass", bus.instr, 16'hBEEF);
    idle_inputs();
    step();

    bus.clear_req = 1;
    step();
    bus.clear_req = 0;
    check("busy_rise", bus.busy, 1);
    n = bus.busy ? 1 : 0;
    for (int k = 0; k < 20 && bus.busy; k++) begin
      bus.fetch_req = (k == 1); bus.fetch_addr = 4'(k);
      bus.load_en = (k == 3); bus.load_addr = 4'd1; bus.load_data = 16'h5555;
      step();
      if (k == 1) check("clear_fetch_valid", bus.instr_valid, 0);
      if (k == 3) check("clear_load_err", bus.load_err, 1);
      if (bus.busy) n++;
    end
    idle_inputs();
    check("busy_cycles", n, 8);
    for (int i = 0; i < DEPTH; i++) begin
      bus.fetch_req = 1; bus.fetch_addr = 4'(i);
      step();
      check("cleared_word", bus.instr, NOP);
      check("cleared_valid", bus.instr_valid, 1);
    end
    idle_inputs();

    for (int i = 0; i < DEPTH; i++) begin
      bus.load_en = 1; bus.load_addr = 4'(i); bus.load_data = 16'h1000 + 16'(i);
      step();
    end
    idle_inputs();
    bus.clear_req = 1;
    step();
    bus.clear_req = 0;
    repeat (3) step();
    #2 reset = 1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_instr", bus.instr, NOP);
    @(posedge clk);
    #1 reset = 0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.fetch_req = 1; bus.fetch_addr = 4'(i);
      step();
      check("abort_word", bus.instr, (i < 3) ? NOP : 16'h1000 + 16'(i));
    end
    idle_inputs();

    for (int c = 0; c < 600; c++) begin
      bus.fetch_req  = ($urandom % 4) != 0;
      bus.fetch_addr = 4'($urandom_range(0, 10));
      bus.stall      = ($urandom % 5) == 0;
      bus.load_en    = ($urandom % 3) == 0;
      bus.load_addr  = (($urandom % 4) == 0) ? bus.fetch_addr : 4'($urandom_range(0, 11));
      bus.load_data  = 16'($urandom);
      bus.clear_req  = ($urandom % 100) == 0;
      step();
    end
    idle_inputs();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_mem_sync.md
# instr_mem_sync

Parametrised, synchronous successor to the combinational instruction memory. It provides a registered fetch port with a valid flag, a pipeline stall hold, and a program-load write port for bootloading. It also has a hardware clear sequencer that fills the whole array with a NOP, and flags out-of-range fetches and loads. It sits between the PC/fetch stage and the decode stage of the 16-bit processor.

## Interface
- DATA_W, 16: instruction width in bits.
- ADDR_W, 10: address width in bits.
- DEPTH, 1024: number of words; must satisfy 1 <= DEPTH <= 2^ADDR_W.
- NOP_INSTR, 0: instruction returned on reset, on faults, and written by the clear sequence.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_req  input  1  fetch request.
- fetch_addr  input  ADDR_W  fetch word address.
- stall  input  1  hold the output register and ignore fetch_req.
- instr  output  DATA_W  registered instruction.
- instr_valid  output  1  instr/instr_addr/fault carry a fetch result.
- instr_addr  output  ADDR_W  address the current instr was fetched from.
- fault  output  1  current result came from an address >= DEPTH.
- load_en  input  1  write load_data to load_addr.
- load_addr  input  ADDR_W  load word address.
- load_data  input  DATA_W  load word.
- load_err  output  1  one-cycle pulse: load was dropped (out of range or busy).
- clear_req  input  1  start the clear sequence.
- busy  output  1  clear sequence in progress.

## Operation
- Reset values:
  - instr = NOP_INSTR; instr_valid = 0; instr_addr = 0; fault = 0; load_err = 0; busy = 0.
  - FSM = IDLE; clear counter = 0.
  - Array contents are not reset.
- FSM states:
  - IDLE: clear_req = 1 -> CLEAR with counter = 0.
  - CLEAR: each cycle writes NOP_INSTR to array[counter] and increments the counter. After the write at DEPTH-1 -> IDLE.
  - clear_req in CLEAR is ignored.
- busy = 1 exactly while the FSM is in CLEAR.
- Fetch, in IDLE with stall = 0 and fetch_req = 1:
  - fetch_addr < DEPTH: instr = array[fetch_addr], fault = 0.
  - fetch_addr >= DEPTH: instr = NOP_INSTR, fault = 1.
  - In both cases instr_valid = 1 and instr_addr = fetch_addr.
- No fetch (fetch_req = 0, stall = 0, or in CLEAR): instr_valid = 0. instr, instr_addr and fault keep their last values.
- stall = 1: instr, instr_valid, instr_addr and fault all hold their previous values. fetch_req is dropped and must be re-presented by the requester.
- Load, in IDLE with load_en = 1 and load_addr < DEPTH: the array is written at the clock edge.
- load_err = 1 on the cycle after a load that is dropped. A load is dropped when:
  - load_addr >= DEPTH, or
  - the FSM is in CLEAR.
- Read-during-write: if a fetch and a load hit the same in-range address in the same cycle, the fetch returns load_data (write-first bypass). This applies during stall = 0 only.
- clear_req and fetch_req together in IDLE: the fetch is serviced from pre-clear contents, and CLEAR begins next cycle.
- clear_req and load_en together in IDLE: the load is performed. The clear then overwrites it.
- Reset during CLEAR: the sequence aborts and the FSM returns to IDLE. Already-cleared words stay cleared; the rest keep their prior contents.

## Timing
- Fetch latency is 1 cycle. A request sampled at edge N appears on instr/instr_valid after edge N, during cycle N+1.
- Fetch throughput is one per cycle, back-to-back, with no bubbles while stall = 0.
- A load is visible to a fetch of the same address in the same cycle (bypass) and in every later cycle.
- A clear takes exactly DEPTH cycles:
  - busy rises the cycle after clear_req is sampled.
  - busy falls DEPTH cycles later.
  - The first fetch is accepted on the cycle busy reads 0.
- A stall asserted in cycle N freezes the outputs from N+1 until the cycle after stall deasserts.
- Reset acts asynchronously: outputs take their reset values immediately, with no clock edge needed.

## Test plan
- Reset, then load addresses 0..6 with 16'h2C03, 16'h8180, 16'h2204, 16'h0083, 16'h6182, 16'hA102, 16'h4581. Fetch 0..6 back-to-back. Required: each word returned one cycle later, instr_valid = 1 throughout, instr_addr = 0..6, fault = 0.
- DEPTH = 8: fetch address 9 -> instr = NOP_INSTR, fault = 1, instr_valid = 1. Load to address 12 -> load_err pulse for 1 cycle, array unchanged.
- Fetch address 3, then assert stall for 3 cycles while driving fetch_req to address 4. Required: instr stays 16'h0083 with instr_valid = 1 throughout the stall. After release, re-presenting address 4 returns 16'h6182.
- Same-cycle load 16'hBEEF to address 5 and fetch of address 5 -> instr = 16'hBEEF next cycle.
- DEPTH = 8: assert clear_req. Required:
  - busy = 1 for exactly 8 cycles.
  - A fetch during the clear gives instr_valid = 0.
  - A load during the clear gives a load_err pulse.
  - Afterwards, all 8 words fetch as NOP_INSTR.
- DEPTH = 8: start a clear and assert reset after 3 cycles. Required: busy = 0 immediately. Addresses 0..2 read NOP_INSTR; addresses 3..7 keep their old data.
